// File: rtl/sigma_delta_pkg.sv
// Shared helpers for the multi-channel sigma-delta DAC.
//   half_scale        : H = 2^(bitlen-1), the modulator feedback magnitude
//   sat_add           : signed add clamped to a given two's complement width
//   to_signed_sample  : raw sample (offset binary or two's complement) -> signed x
// All arithmetic is carried in ExtW bits, wide enough for every legal
// DAC_BITLEN (4..24), since the widest integrator is DAC_BITLEN+4 bits.
package sigma_delta_pkg;

  localparam int unsigned MinBitlen = 4;
  localparam int unsigned MaxBitlen = 24;
  localparam int unsigned MaxCh     = 8;
  localparam int unsigned ExtW      = 32;

  function automatic int half_scale(input int unsigned bitlen);
    return 1 << (bitlen - 1);
  endfunction

  // Saturating add: the result is clamped to [-2^(width-1), 2^(width-1)-1] so
  // integrators pin at their limits instead of wrapping.
  function automatic logic signed [ExtW-1:0] sat_add(input logic signed [ExtW-1:0] a,
                                                     input logic signed [ExtW-1:0] b,
                                                     input int unsigned            width);
    logic signed [ExtW-1:0] sum;
    logic signed [ExtW-1:0] hi;
    logic signed [ExtW-1:0] lo;
    sum = a + b;
    hi  = (32'sd1 <<< (width - 1)) - 32'sd1;
    lo  = -(32'sd1 <<< (width - 1));
    if (sum > hi) begin
      return hi;
    end else if (sum < lo) begin
      return lo;
    end
    return sum;
  endfunction

  // Offset binary: x = u - H. Two's complement: sign-extend from bit bitlen-1,
  // done as (s ^ H) - H on the zero-extended value.
  function automatic logic signed [ExtW-1:0] to_signed_sample(input logic [ExtW-1:0] sample,
                                                              input bit              input_signed,
                                                              input int unsigned     bitlen);
    logic [ExtW-1:0]        mask;
    logic signed [ExtW-1:0] s;
    logic signed [ExtW-1:0] h;
    mask = (32'd1 << bitlen) - 32'd1;
    s    = $signed(sample & mask);
    h    = 32'sd1 <<< (bitlen - 1);
    if (input_signed) begin
      return (s ^ h) - h;
    end
    return s - h;
  endfunction

endpackage

// File: rtl/sigma_delta_mod.sv
// Single-channel first- or second-order sigma-delta modulator.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   x        : signed input sample, sign-extended to ExtW bits, range -H..H-1
//   pin      : registered 1-bit output stream, updated every clock
// a1 is DAC_BITLEN+2 bits, a2 is DAC_BITLEN+4 bits; both saturate.
module sigma_delta_mod
  import sigma_delta_pkg::*;
#(
  parameter int unsigned DAC_BITLEN = 16,
  parameter int unsigned ORDER      = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic signed [ExtW-1:0] x,
  output logic                   pin
);

  localparam int unsigned A1W = DAC_BITLEN + 2;
  localparam int unsigned A2W = DAC_BITLEN + 4;
  localparam int          H   = half_scale(DAC_BITLEN);

  logic signed [A1W-1:0]  a1_q;
  logic signed [ExtW-1:0] a1_ext;
  logic signed [ExtW-1:0] a1_next;
  logic signed [ExtW-1:0] y;
  logic                   pin_d;

  always_comb begin
    // Feedback follows the pin currently on the output.
    y       = pin ? H : -H;
    a1_ext  = $signed({{(ExtW - A1W){a1_q[A1W-1]}}, a1_q});
    a1_next = sat_add(a1_ext, x - y, A1W);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a1_q <= '0;
      pin  <= 1'b0;
    end else begin
      a1_q <= a1_next[A1W-1:0];
      pin  <= pin_d;
    end
  end

  if (ORDER == 2) begin : g_order2
    logic signed [A2W-1:0]  a2_q;
    logic signed [ExtW-1:0] a2_ext;
    logic signed [ExtW-1:0] a2_next;

    always_comb begin
      a2_ext  = $signed({{(ExtW - A2W){a2_q[A2W-1]}}, a2_q});
      // Second integrator sees the freshly updated a1, not the registered one.
      a2_next = sat_add(a2_ext, a1_next - y, A2W);
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        a2_q <= '0;
      end else begin
        a2_q <= a2_next[A2W-1:0];
      end
    end

    assign pin_d = (a2_next >= 0);
  end else if (ORDER == 1) begin : g_order1
    assign pin_d = (a1_next >= 0);
  end else begin : g_bad_order
    $error("sigma_delta_mod: ORDER must be 1 or 2");
    assign pin_d = 1'b0;
  end

endmodule

// File: rtl/sigma_delta_dac_mc.sv
// Multi-channel sigma-delta DAC top level.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   dac_input     : NUM_CH packed samples, channel 0 in the LSBs
//   dac_valid     : dac_input is valid
//   dac_ready     : registered; one-deep holding buffer can take a sample
//   dac_mute      : force every channel to midscale (x = 0), registered
//   dac_underrun  : one-cycle pulse after a period tick that found hold empty
//   dac_pin       : per-channel modulator bitstreams
// A sample is captured into hold on valid&&ready, moved to active on the next
// period tick (osr_cnt == OSR-1) and drives the modulators from then on.
module sigma_delta_dac_mc
  import sigma_delta_pkg::*;
#(
  parameter int unsigned DAC_BITLEN   = 16,
  parameter int unsigned NUM_CH       = 2,
  parameter int unsigned ORDER        = 1,
  parameter int unsigned OSR          = 256,
  parameter int unsigned INPUT_SIGNED = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH*DAC_BITLEN-1:0] dac_input,
  input  logic                         dac_valid,
  output logic                         dac_ready,
  input  logic                         dac_mute,
  output logic                         dac_underrun,
  output logic [NUM_CH-1:0]            dac_pin
);

  localparam int unsigned SampleW = NUM_CH * DAC_BITLEN;
  localparam int unsigned CntW    = $clog2(OSR);
  // Raw code whose converted value is x = 0.
  localparam logic [DAC_BITLEN-1:0] MidCode = {INPUT_SIGNED == 0, {(DAC_BITLEN - 1){1'b0}}};

  if (DAC_BITLEN < MinBitlen || DAC_BITLEN > MaxBitlen || NUM_CH < 1 || NUM_CH > MaxCh ||
      OSR < 2) begin : g_bad_cfg
    $error("sigma_delta_dac_mc: parameter out of range");
  end

  logic [SampleW-1:0] hold_q;
  logic [SampleW-1:0] active_q;
  logic               hold_full_q;
  logic               hold_full_d;
  logic               ready_q;
  logic               underrun_q;
  logic               mute_q;
  logic [CntW-1:0]    osr_cnt_q;
  logic [CntW-1:0]    osr_cnt_d;
  logic               tick;
  logic               accept;

  always_comb begin
    tick      = (osr_cnt_q == CntW'(OSR - 1));
    accept    = dac_valid & ready_q;
    osr_cnt_d = tick ? '0 : osr_cnt_q + CntW'(1);
    // ready is low whenever hold is full, so accept and a consuming tick can
    // never coincide; an accept on an empty tick refills hold for next period.
    if (accept) begin
      hold_full_d = 1'b1;
    end else if (tick) begin
      hold_full_d = 1'b0;
    end else begin
      hold_full_d = hold_full_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q      <= '0;
      active_q    <= {NUM_CH{MidCode}};
      hold_full_q <= 1'b0;
      ready_q     <= 1'b0;
      underrun_q  <= 1'b0;
      mute_q      <= 1'b0;
      osr_cnt_q   <= '0;
    end else begin
      osr_cnt_q   <= osr_cnt_d;
      hold_full_q <= hold_full_d;
      ready_q     <= ~hold_full_d;
      underrun_q  <= tick & ~hold_full_q;
      mute_q      <= dac_mute;
      if (accept) begin
        hold_q <= dac_input;
      end
      if (tick && hold_full_q) begin
        active_q <= hold_q;
      end
    end
  end

  assign dac_ready    = ready_q;
  assign dac_underrun = underrun_q;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic signed [ExtW-1:0] x;

    assign x = mute_q ? '0 :
               to_signed_sample(ExtW'(active_q[ch*DAC_BITLEN +: DAC_BITLEN]),
                                INPUT_SIGNED != 0, DAC_BITLEN);

    sigma_delta_mod #(
      .DAC_BITLEN(DAC_BITLEN),
      .ORDER     (ORDER)
    ) u_mod (
      .clk(clk),
      .rst(rst),
      .x  (x),
      .pin(dac_pin[ch])
    );
  end

endmodule

// File: doc/sigma_delta_dac_mc.md
# sigma_delta_dac_mc

Multi-channel, parametrised sigma-delta DAC. Each channel has a first- or second-order modulator driving a 1-bit pin every `clk`. Input samples arrive through a valid/ready handshake into a one-deep holding buffer and are applied at a fixed oversampling rate, with underrun reporting. It sits between the sample source (DSP/audio path) and the FPGA output pins, which feed external RC filters.

## Interface
- `DAC_BITLEN`, 16: sample width per channel (4..24).
- `NUM_CH`, 2: number of channels sharing one handshake (1..8).
- `ORDER`, 1: modulator order, 1 or 2; any other value is an elaboration error.
- `OSR`, 256: clocks per sample period (≥2).
- `INPUT_SIGNED`, 0: 0 = offset binary input, 1 = two's complement input.
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `dac_input` in NUM_CH×DAC_BITLEN: packed samples, channel 0 in the LSBs.
- `dac_valid` in 1: `dac_input` is valid.
- `dac_ready` out 1: holding buffer can accept a sample.
- `dac_mute` in 1: force all channels to midscale.
- `dac_underrun` out 1: one-cycle pulse when a sample period starts with no new sample.
- `dac_pin` out NUM_CH: modulator bitstreams.

## Operation
- **Handshake:** a transfer occurs on a rising edge with `dac_valid && dac_ready`. All channels are captured into `hold` and `hold_full` is set.
- **Period tick:** `osr_cnt` counts 0..OSR-1 and wraps. A tick occurs in the cycle with `osr_cnt == OSR-1`.
  - If `hold_full`: `active <= hold` and `hold_full` clears.
  - Otherwise `active` keeps its value and `dac_underrun` pulses.
- **Accept on a tick with an empty buffer:** the sample goes to `hold` only and is applied at the next tick. There is no bypass.
- **Input conversion:** each channel converts its sample to signed `x` with range -H..H-1, where H = 2^(DAC_BITLEN-1).
  - Offset binary: x = u - H.
  - Signed input: x = sample.
  - `dac_mute` high forces x = 0 from the next edge. Integrators keep running.
- **Modulator step** (every clock, per channel):
  - Feedback: y = +H if the current pin is 1, otherwise -H.
  - ORDER 1: a1 <= a1 + x - y; pin <= (a1_next ≥ 0).
  - ORDER 2: a1 <= a1 + x - y; a2 <= a2 + a1_next - y; pin <= (a2_next ≥ 0).
- **Widths:** `a1` is DAC_BITLEN+2 bits signed; `a2` is DAC_BITLEN+4 bits signed. Both saturate to their range limits and never wrap.
- **Mean pin density:** (x+H)/2^N. Midscale gives 50%.
- **Reset mid-operation:** clears everything immediately. Any sample in flight is dropped.

## Timing
- **Reset values:**
  - `dac_pin` = 0, `dac_ready` = 0, `dac_underrun` = 0.
  - `hold_full` = 0, `osr_cnt` = 0, `active` = midscale (x = 0), `a1` = `a2` = 0.
- **Ready after reset:** `dac_ready` is registered and goes 1 on the first edge after `rst` deasserts.
- **Ready protocol:** `dac_ready` = registered `!hold_full_next`. It drops the cycle after an accept and rises the cycle after the consuming tick.
- **Latency:** a sample accepted at edge t is applied at the first tick edge after t. From that edge it reaches `dac_pin` one clock later.
- **Pin update:** `dac_pin` updates every clock, with no gating by `osr_cnt`.
- **Underrun pulse:** `dac_underrun` is high for exactly the cycle after the tick edge.
- **First tick after reset:** the tick at `osr_cnt = OSR-1` with no sample produces an underrun.

## Structure
- **Package `sigma_delta_pkg`:**
  - localparam H derivation.
  - Saturating add function, parametrised by width.
  - `to_signed_sample(sample, INPUT_SIGNED)` conversion function.
- **Sub-module `sigma_delta_mod`:** single-channel modulator (`clk`, `rst`, x, pin), parameters `DAC_BITLEN` and `ORDER`. The top instantiates it NUM_CH times in a generate loop.
- **Top level:** handshake, `hold`/`active` registers, `osr_cnt`, mute and underrun logic.

## Test plan
All scenarios use DAC_BITLEN=8, OSR=16, NUM_CH=2.
- **Reset:** assert `rst` mid-stream with hold full → all outputs 0 immediately. `dac_ready` = 1 one edge after release. First tick pulses `dac_underrun`.
- **ORDER 1 density:** ch0 u=0x80, ch1 u=0xFF, fed every period. Over 256 clocks ch0 has 128±1 ones and ch1 has 255±1 ones.
- **ORDER 2 density:** u=0x40 and 0xC0. Over 1024 clocks pin ones are 256±2 and 768±2. `a1`/`a2` never exceed their saturation limits.
- **Handshake:**
  - `dac_valid` held high → exactly one accept per 16 clocks, no underrun.
  - Accept on a tick edge with an empty buffer → sample applied 16 clocks later.
- **Underrun:** stop `dac_valid` for 3 periods → three single-cycle pulses; `active` unchanged and the density holds the last sample.
- **Signed mode and mute:**
  - INPUT_SIGNED=1, x=-128 → pin all 0 after settling.
  - `dac_mute`=1 with x=0x7F → 50%±1 density.
